// File: rtl/aibnd_io_seq_ctrl.sv
// aibnd_io_seq_ctrl: sequences an IO pad between off/tx/rx/loopback modes.
// Each accepted request quiesces the pad, releases pad reset, waits a settle
// time, brings drive strength up to target, then applies the mode enables.
// Build option: define AIBND_SEQ_DRV_RAMP_EN to step drive strength up one
// code per cycle; when undefined the drive jumps straight to target.
// Every output is driven from a register.
module aibnd_io_seq_ctrl (
    input  logic       iclk,
    input  logic       irst,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic [1:0] cfg_pdrv,
    input  logic [1:0] cfg_ndrv,
    input  logic [2:0] cfg_rxen,
    input  logic [3:0] cfg_settle,
    output logic       ipadrstb,
    output logic       itx_en,
    output logic       ilpbk_en,
    output logic [2:0] irxen,
    output logic [1:0] ipdrv,
    output logic [1:0] indrv,
    output logic       busy,
    output logic       active
);

    localparam logic [1:0] ModeOff  = 2'b00;
    localparam logic [1:0] ModeTx   = 2'b01;
    localparam logic [1:0] ModeRx   = 2'b10;
    localparam logic [1:0] ModeLpbk = 2'b11;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StQuiesce = 3'd1,
        StSettle  = 3'd2,
`ifdef AIBND_SEQ_DRV_RAMP_EN
        StRamp    = 3'd3,
`endif
        StEnable  = 3'd4,
        StActive  = 3'd5
    } state_e;

    state_e     state_q, state_d;

    // Request captured at acceptance; live inputs are ignored until the next one.
    logic [1:0] mode_q, mode_d;
    logic [1:0] pdrv_tgt_q, pdrv_tgt_d;
    logic [1:0] ndrv_tgt_q, ndrv_tgt_d;
    logic [2:0] rxen_cfg_q, rxen_cfg_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] cnt_q, cnt_d;

    // Registered pad-facing outputs.
    logic       padrstb_q, padrstb_d;
    logic       tx_en_q, tx_en_d;
    logic       lpbk_en_q, lpbk_en_d;
    logic [2:0] rxen_q, rxen_d;
    logic [1:0] pdrv_q, pdrv_d;
    logic [1:0] ndrv_q, ndrv_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       active_q, active_d;

    logic       accept;

`ifdef AIBND_SEQ_DRV_RAMP_EN
    logic [1:0] pdrv_step;
    logic [1:0] ndrv_step;
`endif

    assign accept = mode_valid & ready_q;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pdrv_tgt_d = pdrv_tgt_q;
        ndrv_tgt_d = ndrv_tgt_q;
        rxen_cfg_d = rxen_cfg_q;
        settle_d   = settle_q;
        cnt_d      = cnt_q;
        padrstb_d  = padrstb_q;
        tx_en_d    = tx_en_q;
        lpbk_en_d  = lpbk_en_q;
        rxen_d     = rxen_q;
        pdrv_d     = pdrv_q;
        ndrv_d     = ndrv_q;
`ifdef AIBND_SEQ_DRV_RAMP_EN
        // Saturating one-code step toward each target.
        pdrv_step  = (pdrv_q < pdrv_tgt_q) ? pdrv_q + 2'd1 : pdrv_q;
        ndrv_step  = (ndrv_q < ndrv_tgt_q) ? ndrv_q + 2'd1 : ndrv_q;
`endif

        case (state_q)
            StIdle, StActive: begin
                if (accept) begin
                    mode_d     = mode_req;
                    pdrv_tgt_d = cfg_pdrv;
                    ndrv_tgt_d = cfg_ndrv;
                    rxen_cfg_d = cfg_rxen;
                    settle_d   = cfg_settle;
                    // Enables and drive all drop together; pad reset is left as is.
                    tx_en_d    = 1'b0;
                    lpbk_en_d  = 1'b0;
                    rxen_d     = 3'b000;
                    pdrv_d     = 2'b00;
                    ndrv_d     = 2'b00;
                    state_d    = StQuiesce;
                end
            end
            StQuiesce: begin
                if (mode_q == ModeOff) begin
                    padrstb_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    padrstb_d = 1'b1;
                    cnt_d     = settle_q;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
`ifdef AIBND_SEQ_DRV_RAMP_EN
                    if ((pdrv_tgt_q == 2'b00) && (ndrv_tgt_q == 2'b00)) begin
                        state_d = StEnable;
                    end else begin
                        state_d = StRamp;
                    end
`else
                    pdrv_d  = pdrv_tgt_q;
                    ndrv_d  = ndrv_tgt_q;
                    state_d = StEnable;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef AIBND_SEQ_DRV_RAMP_EN
            StRamp: begin
                pdrv_d = pdrv_step;
                ndrv_d = ndrv_step;
                if ((pdrv_step == pdrv_tgt_q) && (ndrv_step == ndrv_tgt_q)) begin
                    state_d = StEnable;
                end
            end
`endif
            StEnable: begin
                state_d = StActive;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Mode enables are applied on entry to ENABLE and then held through ACTIVE.
        if (state_d == StEnable) begin
            case (mode_q)
                ModeTx: begin
                    tx_en_d = 1'b1;
                end
                ModeRx: begin
                    rxen_d = rxen_cfg_q;
                end
                ModeLpbk: begin
                    tx_en_d   = 1'b1;
                    lpbk_en_d = 1'b1;
                    rxen_d    = rxen_cfg_q;
                end
                default: begin
                    tx_en_d = 1'b0;
                end
            endcase
        end

        ready_d  = (state_d == StIdle) || (state_d == StActive);
        busy_d   = ~ready_d;
        active_d = (state_d == StActive);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= StIdle;
            mode_q     <= ModeOff;
            pdrv_tgt_q <= 2'b00;
            ndrv_tgt_q <= 2'b00;
            rxen_cfg_q <= 3'b000;
            settle_q   <= 4'd0;
            cnt_q      <= 4'd0;
            padrstb_q  <= 1'b0;
            tx_en_q    <= 1'b0;
            lpbk_en_q  <= 1'b0;
            rxen_q     <= 3'b000;
            pdrv_q     <= 2'b00;
            ndrv_q     <= 2'b00;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pdrv_tgt_q <= pdrv_tgt_d;
            ndrv_tgt_q <= ndrv_tgt_d;
            rxen_cfg_q <= rxen_cfg_d;
            settle_q   <= settle_d;
            cnt_q      <= cnt_d;
            padrstb_q  <= padrstb_d;
            tx_en_q    <= tx_en_d;
            lpbk_en_q  <= lpbk_en_d;
            rxen_q     <= rxen_d;
            pdrv_q     <= pdrv_d;
            ndrv_q     <= ndrv_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            active_q   <= active_d;
        end
    end

    assign mode_ready = ready_q;
    assign busy       = busy_q;
    assign active     = active_q;
    assign ipadrstb   = padrstb_q;
    assign itx_en     = tx_en_q;
    assign ilpbk_en   = lpbk_en_q;
    assign irxen      = rxen_q;
    assign ipdrv      = pdrv_q;
    assign indrv      = ndrv_q;

endmodule

// File: tb/tb_aibnd_io_seq_ctrl.sv
// Directed bench for aibnd_io_seq_ctrl. Expected output snapshots are queued
// as each step's stimulus is applied and compared after the following edge.
// Expectations follow AIBND_SEQ_DRV_RAMP_EN when it is defined.
module tb_aibnd_io_seq_ctrl;

    logic       iclk;
    logic       irst;
    logic [1:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;
    logic [1:0] cfg_pdrv;
    logic [1:0] cfg_ndrv;
    logic [2:0] cfg_rxen;
    logic [3:0] cfg_settle;
    logic       ipadrstb;
    logic       itx_en;
    logic       ilpbk_en;
    logic [2:0] irxen;
    logic [1:0] ipdrv;
    logic [1:0] indrv;
    logic       busy;
    logic       active;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    logic [12:0] obs;

    aibnd_io_seq_ctrl dut (
        .iclk       (iclk),
        .irst       (irst),
        .mode_req   (mode_req),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .cfg_pdrv   (cfg_pdrv),
        .cfg_ndrv   (cfg_ndrv),
        .cfg_rxen   (cfg_rxen),
        .cfg_settle (cfg_settle),
        .ipadrstb   (ipadrstb),
        .itx_en     (itx_en),
        .ilpbk_en   (ilpbk_en),
        .irxen      (irxen),
        .ipdrv      (ipdrv),
        .indrv      (indrv),
        .busy       (busy),
        .active     (active)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    assign obs = {ipadrstb, itx_en, ilpbk_en, irxen, ipdrv, indrv, busy, active, mode_ready};

    // Packs an expected output snapshot; busy is the complement of mode_ready.
    function automatic logic [12:0] ex(input logic rstb, input logic tx, input logic lp,
                                       input logic [2:0] rx, input logic [1:0] pd,
                                       input logic [1:0] nd, input logic act,
                                       input logic rdy);
        return {rstb, tx, lp, rx, pd, nd, ~rdy, act, rdy};
    endfunction

    task automatic check_pop();
        logic [12:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (rstb,tx,lp,rx,pd,nd,busy,act,rdy)",
                   t, obs, e);
        end
    endtask

    // Queue the expectation for the coming edge, clock once, then compare.
    task automatic step(input string tag, input logic [12:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge iclk);
        #1;
        check_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        irst       = 1'b1;
        mode_req   = 2'b00;
        mode_valid = 1'b0;
        cfg_pdrv   = 2'b00;
        cfg_ndrv   = 2'b00;
        cfg_rxen   = 3'b000;
        cfg_settle = 4'd0;

        step("reset_a", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));
        // Held request during reset must be dropped.
        mode_valid = 1'b1;
        mode_req   = 2'b01;
        step("reset_b", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));
        irst       = 1'b0;
        mode_valid = 1'b0;
        step("idle", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));

        // tx, settle=2, pdrv=3, ndrv=1; inputs scrambled after acceptance.
        mode_req   = 2'b01;
        cfg_pdrv   = 2'd3;
        cfg_ndrv   = 2'd1;
        cfg_rxen   = 3'b111;
        cfg_settle = 4'd2;
        mode_valid = 1'b1;
        step("t1_quiesce", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_valid = 1'b0;
        mode_req   = 2'b11;
        cfg_pdrv   = 2'd0;
        cfg_ndrv   = 2'd2;
        cfg_settle = 4'd9;
        step("t1_settle_a", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t1_settle_b", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t1_settle_c", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
`ifdef AIBND_SEQ_DRV_RAMP_EN
        step("t1_ramp0", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t1_ramp1", ex(1, 0, 0, 3'b000, 2'd1, 2'd1, 0, 0));
        step("t1_ramp2", ex(1, 0, 0, 3'b000, 2'd2, 2'd1, 0, 0));
`endif
        step("t1_enable", ex(1, 1, 0, 3'b000, 2'd3, 2'd1, 0, 0));
        step("t1_active", ex(1, 1, 0, 3'b000, 2'd3, 2'd1, 1, 1));
        step("t1_hold", ex(1, 1, 0, 3'b000, 2'd3, 2'd1, 1, 1));

        // rx from ACTIVE, settle=0, no drive, rxen=101.
        mode_req   = 2'b10;
        cfg_pdrv   = 2'd0;
        cfg_ndrv   = 2'd0;
        cfg_rxen   = 3'b101;
        cfg_settle = 4'd0;
        mode_valid = 1'b1;
        step("t2_quiesce", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_valid = 1'b0;
        step("t2_settle", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t2_enable", ex(1, 0, 0, 3'b101, 2'd0, 2'd0, 0, 0));
        step("t2_active", ex(1, 0, 0, 3'b101, 2'd0, 2'd0, 1, 1));

        // loopback, settle=1, pdrv=1, ndrv=2, rxen=011; off requested mid-SETTLE.
        mode_req   = 2'b11;
        cfg_pdrv   = 2'd1;
        cfg_ndrv   = 2'd2;
        cfg_rxen   = 3'b011;
        cfg_settle = 4'd1;
        mode_valid = 1'b1;
        step("t3_quiesce", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_valid = 1'b0;
        step("t3_settle_a", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_req   = 2'b00;
        cfg_pdrv   = 2'd3;
        cfg_ndrv   = 2'd3;
        mode_valid = 1'b1;
        step("t3_settle_b", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
`ifdef AIBND_SEQ_DRV_RAMP_EN
        step("t3_ramp0", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t3_ramp1", ex(1, 0, 0, 3'b000, 2'd1, 2'd1, 0, 0));
`endif
        step("t3_enable", ex(1, 1, 1, 3'b011, 2'd1, 2'd2, 0, 0));
        step("t3_active", ex(1, 1, 1, 3'b011, 2'd1, 2'd2, 1, 1));
        // The held off request is accepted now that ACTIVE raised mode_ready.
        step("t4_off_quiesce", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_valid = 1'b0;
        step("t4_off_idle", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));
        step("t4_idle_hold", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));

        // Reset mid-SETTLE with a concurrent request.
        mode_req   = 2'b01;
        cfg_pdrv   = 2'd3;
        cfg_ndrv   = 2'd3;
        cfg_settle = 4'd5;
        mode_valid = 1'b1;
        step("t5_quiesce", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_valid = 1'b0;
        step("t5_settle_a", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t5_settle_b", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        irst       = 1'b1;
        mode_valid = 1'b1;
        step("t5_reset", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));
        irst       = 1'b0;
        mode_valid = 1'b0;
        step("t5_idle", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 1));

        // tx, maximum settle=15, drive 3/3.
        mode_req   = 2'b01;
        cfg_pdrv   = 2'd3;
        cfg_ndrv   = 2'd3;
        cfg_rxen   = 3'b110;
        cfg_settle = 4'd15;
        mode_valid = 1'b1;
        step("t6_quiesce", ex(0, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        mode_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step($sformatf("t6_settle_%0d", i), ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        end
`ifdef AIBND_SEQ_DRV_RAMP_EN
        step("t6_ramp0", ex(1, 0, 0, 3'b000, 2'd0, 2'd0, 0, 0));
        step("t6_ramp1", ex(1, 0, 0, 3'b000, 2'd1, 2'd1, 0, 0));
        step("t6_ramp2", ex(1, 0, 0, 3'b000, 2'd2, 2'd2, 0, 0));
`endif
        step("t6_enable", ex(1, 1, 0, 3'b000, 2'd3, 2'd3, 0, 0));
        step("t6_active", ex(1, 1, 0, 3'b000, 2'd3, 2'd3, 1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
